fetch_unit: RTL and testbench

Instruction fetch stage that drives the word-aligned byte address into the asynchronous instruction ROM and consumes the returned 32-bit word. It owns the program counter and buffers fetched instructions in a 2-entry queue toward decode, using a valid/ready handshake. It also accepts redirects (branch/jump targets) from downstream and halts with a sticky fault on illegal fetch addresses.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // A fetch address is usable only if word-aligned and inside the ROM.
    function automatic logic pc_legal(input logic [ADDR_W-1:0] pc,
                                      input logic [ADDR_W-1:0] limit);
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; slot 0 is always the head.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enq,
    input  logic         i_deq,
    input  logic         i_flush,
    input  fetch_entry_t i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_head  = r_slot0;

    assign w_pop  = i_deq && !o_empty;
    assign w_push = i_enq && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else if (w_pop && w_push) begin
            // Count is unchanged; shift when full so order is preserved.
            if (r_count == 2'd2) begin
                r_slot0 <= r_slot1;
                r_slot1 <= i_din;
            end else begin
                r_slot0 <= i_din;
            end
        end else if (w_pop) begin
            r_slot0 <= r_slot1;
            r_count <= r_count - 2'd1;
        end else if (w_push) begin
            if (r_count == 2'd0) begin
                r_slot0 <= i_din;
            end else begin
                r_slot1 <= i_din;
            end
            r_count <= r_count + 2'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the async ROM, queues words toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 256
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault
);

    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_SIZE * 4);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_fault;
    logic              w_fault_nxt;

    logic              w_enq;
    logic              w_flush;
    logic              w_deq;
    logic              w_q_full;
    logic              w_q_empty;
    logic [1:0]        w_q_count;
    logic              w_unused_q;
    fetch_entry_t      w_enq_entry;
    fetch_entry_t      w_head;

    assign imem_addr = r_pc;
    assign fault     = r_fault;
    assign out_valid = !w_q_empty;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign w_deq     = out_valid && out_ready;

    assign w_enq_entry.pc    = r_pc;
    assign w_enq_entry.instr = imem_data;
    assign w_unused_q        = ^w_q_count;

    fetch_queue u_queue (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_enq   (w_enq),
        .i_deq   (w_deq),
        .i_flush (w_flush),
        .i_din   (w_enq_entry),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Redirect outranks fetch and is the only way out of HALT besides reset.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_enq       = 1'b0;
        w_flush     = 1'b0;
        if (redirect_valid) begin
            w_flush = 1'b1;
            if (pc_legal(redirect_pc, PC_LIMIT)) begin
                w_pc_nxt    = redirect_pc;
                w_state_nxt = RUN;
                w_fault_nxt = 1'b0;
            end else begin
                w_state_nxt = HALT;
                w_fault_nxt = 1'b1;
            end
        end else if (r_state == RUN) begin
            if (!pc_legal(r_pc, PC_LIMIT)) begin
                w_state_nxt = HALT;
                w_fault_nxt = 1'b1;
            end else if (!w_q_full || w_deq) begin
                w_enq    = 1'b1;
                w_pc_nxt = r_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          MEM_SIZE = 64;
    localparam int          AW       = $clog2(MEM_SIZE) + 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] LIMIT    = 32'(MEM_SIZE * 4);

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    logic [31:0] rom [0:MEM_SIZE-1];

    fetch_unit #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    assign imem_data = (imem_addr < LIMIT) ? rom[imem_addr[AW-1:2]] : 32'hBAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what decode should see, in plain queue terms.
    fetch_entry_t m_q[$];
    fetch_entry_t sb_q[$];
    logic [31:0]  m_pc    = RESET_PC;
    bit           m_halt  = 1'b0;
    bit           m_fault = 1'b0;

    bit           e_valid;
    bit           e_fault;
    logic [31:0]  e_addr;
    bit           chk_en   = 1'b0;
    bit           prev_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the model across the coming edge.
    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rp, input bit rdy);
        fetch_entry_t e;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            chk("rst_out_pc", out_pc, 32'h0);
            chk("rst_out_instr", out_instr, 32'h0);
        end
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        e_valid = (m_q.size() > 0);
        e_fault = m_fault;
        e_addr  = m_pc;
        if (m_q.size() > 0 && rdy) begin
            sb_q.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (rst) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_halt  = 1'b0;
            m_fault = 1'b0;
        end else if (rv) begin
            m_q.delete();
            if (rp[1:0] != 2'b00 || rp >= LIMIT) begin
                m_halt  = 1'b1;
                m_fault = 1'b1;
            end else begin
                m_pc    = rp;
                m_halt  = 1'b0;
                m_fault = 1'b0;
            end
        end else if (!m_halt) begin
            if (m_pc >= LIMIT) begin
                m_halt  = 1'b1;
                m_fault = 1'b1;
            end else if (m_q.size() < 2) begin
                e.pc    = m_pc;
                e.instr = rom[m_pc[AW-1:2]];
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        prev_rst = rst;
        chk_en   = 1'b1;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (chk_en) begin
            fetch_entry_t x;
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("fault", 32'(fault), 32'(e_fault));
            chk("imem_addr", imem_addr, e_addr);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_emit actual_pc=%h expected=none", out_pc);
                end else begin
                    x = sb_q.pop_front();
                    chk("out_pc", out_pc, x.pc);
                    chk("out_instr", out_instr, x.instr);
                end
            end
            while (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_emit actual=none expected_pc=%h", x.pc);
            end
        end
    end

    initial begin
        logic [31:0] t;
        int          sel;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) rom[i] = $urandom;
        rom[0] = 32'h1111_1111;
        rom[1] = 32'h2222_2222;
        rom[2] = 32'h3333_3333;

        repeat (2) cycle(1, 0, 32'h0, 0);
        // Streaming from reset with decode always ready.
        repeat (6) cycle(0, 0, 32'h0, 1);
        // Backpressure: queue fills, PC freezes, then drains in order.
        cycle(1, 0, 32'h0, 0);
        repeat (5) cycle(0, 0, 32'h0, 0);
        repeat (5) cycle(0, 0, 32'h0, 1);
        // Redirect while full.
        repeat (3) cycle(0, 0, 32'h0, 0);
        cycle(0, 1, 32'h40, 0);
        repeat (5) cycle(0, 0, 32'h0, 1);
        // Misaligned redirect halts; legal redirect recovers.
        cycle(0, 1, 32'h42, 1);
        repeat (3) cycle(0, 0, 32'h0, 1);
        cycle(0, 1, 32'h10, 1);
        repeat (4) cycle(0, 0, 32'h0, 1);
        // Run off the end of the ROM.
        cycle(0, 1, LIMIT - 32'd16, 1);
        repeat (8) cycle(0, 0, 32'h0, 1);
        // Boundary redirect targets.
        cycle(0, 1, LIMIT, 1);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 1, LIMIT - 32'd4, 1);
        repeat (3) cycle(0, 0, 32'h0, 1);
        // Reset while full and faulted.
        cycle(0, 1, LIMIT - 32'd8, 0);
        repeat (4) cycle(0, 0, 32'h0, 0);
        cycle(1, 0, 32'h0, 0);
        repeat (3) cycle(0, 0, 32'h0, 1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                cycle(1, 0, 32'h0, $urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 11) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel <= 5)      t = 32'($urandom_range(0, MEM_SIZE - 1)) << 2;
                else if (sel == 6) t = (32'($urandom_range(0, MEM_SIZE - 1)) << 2) | 32'($urandom_range(1, 3));
                else if (sel == 7) t = LIMIT;
                else if (sel == 8) t = LIMIT - 32'd4;
                else               t = $urandom;
                cycle(0, 1, t, $urandom_range(0, 3) != 0);
            end else begin
                cycle(0, 0, 32'h0, $urandom_range(0, 3) != 0);
            end
        end
        repeat (2) cycle(0, 0, 32'h0, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
